// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: frame states, prefix bytes, event field layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam int EV_CODE_LSB = 0;
   localparam int EV_EXT      = 8;
   localparam int EV_BRK      = 9;
   localparam int EV_W        = 16;

   // PS/2 uses odd parity over the 8 data bits plus the parity bit
   function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
      return ^{b, p};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Event-side bus between the PS/2 receiver and the peripheral bus slave.
// Latency: n/a (wires only).
// Backpressure: consumer pops the show-ahead head event via pop while ev_valid.
interface ps2_rx_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   import ps2_pkg::*;

   logic                  pop;
   logic                  clr_status;
   logic                  ev_valid;
   logic [EV_W-1:0]       ev_data;
   logic [DEPTH_LOG2:0]   ev_count;
   logic                  overflow;
   logic [7:0]            err_cnt;

   // receiver side
   modport slave (
      input  pop, clr_status,
      output ev_valid, ev_data, ev_count, overflow, err_cnt
   );

   // bus slave / consumer side
   modport master (
      output pop, clr_status,
      input  ev_valid, ev_data, ev_count, overflow, err_cnt
   );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock show-ahead FIFO with occupancy count and drop flag.
// Latency: write visible at rd_dat/rd_vld/count one clk after wr_vld.
// Backpressure: writes to a full FIFO are dropped (drop pulses) unless a read frees a slot that cycle.
module sync_fifo #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_vld,
   input  logic [WIDTH-1:0]      wr_dat,
   input  logic                  rd_rdy,
   output logic                  rd_vld,
   output logic [WIDTH-1:0]      rd_dat,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  drop
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_wr, do_rd;

   // Accept/refuse decisions and next pointer/count values
   always_comb begin
      do_rd    = rd_rdy && (count_q != '0);
      // a simultaneous read frees the slot, so a full FIFO can still take the write
      do_wr    = wr_vld && ((count_q != FULL_CNT) || do_rd);
      drop     = wr_vld && !do_wr;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_wr && !do_rd) count_d = count_q + 1'b1;
      if (do_rd && !do_wr) count_d = count_q - 1'b1;
   end

   // Pointer and count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; count gates what is visible
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
   end

   assign rd_vld = (count_q != '0);
   assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
   assign count  = count_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: deglitch pins, frame bytes, fold E0/F0 prefixes, queue key events.
// Latency: about FILTER_LEN+5 clk from the stop-bit pin fall to ev_valid.
// Backpressure: none toward the keyboard; events meeting a full FIFO are dropped and flagged.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH_LOG2  = 4,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 50000,
   parameter int DECODE      = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ps2_clk,
   input  logic          ps2_data,
   ps2_rx_fifo_if.slave  ev_if
);

   localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int WDW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]      clk_sync_q, clk_sync_d;
   logic [1:0]      dat_sync_q, dat_sync_d;
   logic            filt_q, filt_d;
   logic [FCW-1:0]  flt_cnt_q, flt_cnt_d;
   logic            fall, dat_s;

   frame_state_e    state_q, state_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic            byte_vld_q, byte_vld_d;
   logic [WDW-1:0]  wd_q, wd_d;
   logic            frame_err;

   logic            ext_q, ext_d;
   logic            brk_q, brk_d;
   logic            push_q, push_d;
   logic [EV_W-1:0] push_dat_q, push_dat_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      err_cnt_q, err_cnt_d;
   logic            fifo_drop;

   // Synchronise both pins, then require FILTER_LEN agreeing samples before the clock moves
   always_comb begin
      clk_sync_d = {clk_sync_q[0], ps2_clk};
      dat_sync_d = {dat_sync_q[0], ps2_data};
      filt_d     = filt_q;
      flt_cnt_d  = '0;
      if (clk_sync_q[1] != filt_q) begin
         if (flt_cnt_q == FCW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
         else flt_cnt_d = flt_cnt_q + 1'b1;
      end
      fall  = filt_q && !filt_d;
      dat_s = dat_sync_q[1];
   end

   // Frame state machine stepped by filtered falling edges, with a stall watchdog
   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      byte_vld_d = 1'b0;
      frame_err  = 1'b0;
      wd_d       = (state_q == IDLE || fall) ? '0 : wd_q + 1'b1;
      if (fall) begin
         unique case (state_q)
            IDLE: begin
               if (!dat_s) begin
                  state_d  = DATA;
                  bitcnt_d = '0;
               end
            end
            DATA: begin
               shift_d  = {dat_s, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = dat_s;
               state_d = STOP;
            end
            STOP: begin
               if (dat_s && odd_parity_ok(shift_q, par_q)) byte_vld_d = 1'b1;
               else frame_err = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && wd_q == WDW'(TIMEOUT_CYC)) begin
         // keyboard stopped clocking mid-frame: drop the partial byte
         state_d   = IDLE;
         frame_err = 1'b1;
      end
   end

   // Prefix decoder builds the event; sticky status follows with clear-vs-new-event priority
   always_comb begin
      ext_d      = ext_q;
      brk_d      = brk_q;
      push_d     = 1'b0;
      push_dat_d = push_dat_q;
      if (byte_vld_q) begin
         if (DECODE != 0) begin
            if (shift_q == PS2_EXT) begin
               ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
               brk_d = 1'b1;
            end else begin
               push_d                           = 1'b1;
               push_dat_d                       = '0;
               push_dat_d[EV_CODE_LSB +: 8]     = shift_q;
               push_dat_d[EV_EXT]               = ext_q;
               push_dat_d[EV_BRK]               = brk_q;
               ext_d                            = 1'b0;
               brk_d                            = 1'b0;
            end
         end else begin
            push_d     = 1'b1;
            push_dat_d = {8'h00, shift_q};
         end
      end

      if (ev_if.clr_status) begin
         ovf_d     = fifo_drop;
         err_cnt_d = frame_err ? 8'd1 : 8'd0;
      end else begin
         ovf_d     = ovf_q || fifo_drop;
         err_cnt_d = (frame_err && err_cnt_q != 8'hFF) ? err_cnt_q + 1'b1 : err_cnt_q;
      end
   end

   // All receiver state; pins idle high so sync and filter reset to 1
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_q     <= 1'b1;
         flt_cnt_q  <= '0;
         state_q    <= IDLE;
         bitcnt_q   <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         byte_vld_q <= 1'b0;
         wd_q       <= '0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         push_q     <= 1'b0;
         push_dat_q <= '0;
         ovf_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         filt_q     <= filt_d;
         flt_cnt_q  <= flt_cnt_d;
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         byte_vld_q <= byte_vld_d;
         wd_q       <= wd_d;
         ext_q      <= ext_d;
         brk_q      <= brk_d;
         push_q     <= push_d;
         push_dat_q <= push_dat_d;
         ovf_q      <= ovf_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   sync_fifo #(
      .WIDTH      (EV_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (push_q),
      .wr_dat (push_dat_q),
      .rd_rdy (ev_if.pop),
      .rd_vld (ev_if.ev_valid),
      .rd_dat (ev_if.ev_data),
      .count  (ev_if.ev_count),
      .drop   (fifo_drop)
   );

   assign ev_if.overflow = ovf_q;
   assign ev_if.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: a decoding and a raw instance share the PS/2 pins.
// A queue-based event model is compared against both DUTs whenever the bus is settled.
// Hand-computed literal expectations pin the model at key points.
module tb_ps2_rx_fifo;

   localparam int DL2 = 2;
   localparam int FL  = 4;
   localparam int TO  = 200;
   localparam int H   = 8;
   localparam int NQ  = 1 << DL2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;

   always #5 clk = ~clk;

   ps2_rx_fifo_if #(.DEPTH_LOG2(DL2)) dif ();
   ps2_rx_fifo_if #(.DEPTH_LOG2(DL2)) rif ();

   ps2_rx_fifo #(.DEPTH_LOG2(DL2), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .DECODE(1)) dut_d (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ev_if(dif));
   ps2_rx_fifo #(.DEPTH_LOG2(DL2), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .DECODE(0)) dut_r (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ev_if(rif));

   // behavioural model
   logic [15:0] qd[$];
   logic [15:0] qr[$];
   logic        ovf_dm = 1'b0;
   logic        ovf_rm = 1'b0;
   logic [7:0]  err_m  = 8'd0;
   logic        ext_m  = 1'b0;
   logic        brk_m  = 1'b0;
   bit          settled = 1'b0;
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // per-cycle comparison of both DUTs against the model
   always @(negedge clk) begin
      if (settled) begin
         chk("d_valid", dif.ev_valid, qd.size() != 0);
         chk("d_data",  dif.ev_data,  (qd.size() != 0) ? qd[0] : 16'h0);
         chk("d_count", dif.ev_count, qd.size());
         chk("d_ovf",   dif.overflow, ovf_dm);
         chk("d_err",   dif.err_cnt,  err_m);
         chk("r_valid", rif.ev_valid, qr.size() != 0);
         chk("r_data",  rif.ev_data,  (qr.size() != 0) ? qr[0] : 16'h0);
         chk("r_count", rif.ev_count, qr.size());
         chk("r_ovf",   rif.overflow, ovf_rm);
         chk("r_err",   rif.err_cnt,  err_m);
      end
   end

   function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit stop);
      return {stop, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   // good byte: decoder folds prefixes; dpop means a pop on the decoded FIFO coincides with the push
   task automatic model_byte(input logic [7:0] b, input bit dpop);
      if (b == 8'hE0) ext_m = 1'b1;
      else if (b == 8'hF0) brk_m = 1'b1;
      else begin
         if (dpop && qd.size() != 0) qd.delete(0);
         if (qd.size() < NQ) qd.push_back({6'b0, brk_m, ext_m, b});
         else ovf_dm = 1'b1;
         ext_m = 1'b0;
         brk_m = 1'b0;
      end
      if (qr.size() < NQ) qr.push_back({8'h00, b});
      else ovf_rm = 1'b1;
   endtask

   task automatic send_bits(input logic [10:0] f, input int nbits, input bit glitch);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         repeat (H) @(negedge clk);
         if (glitch && i == 5) begin
            ps2_clk = 1'b0;
            repeat (FL - 1) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (H) @(negedge clk);
         end
         ps2_clk = 1'b0;
         repeat (H) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic frame(input logic [7:0] b, input bit glitch);
      settled = 1'b0;
      send_bits(mk(b, 1'b0, 1'b1), 11, glitch);
      model_byte(b, 1'b0);
      repeat (30) @(negedge clk);
      settled = 1'b1;
   endtask

   task automatic bad_frame(input logic [10:0] f, input int nbits, input int idle);
      settled = 1'b0;
      send_bits(f, nbits, 1'b0);
      repeat (idle) @(negedge clk);
      if (err_m != 8'hFF) err_m++;
      settled = 1'b1;
   endtask

   // good frame whose FIFO write is aligned with a pop on the decoded instance
   task automatic frame_pop(input logic [7:0] b);
      bit seen;
      seen = 1'b0;
      settled = 1'b0;
      send_bits(mk(b, 1'b0, 1'b1), 10, 1'b0);
      ps2_data = 1'b1;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (dut_d.push_q) begin
            dif.pop = 1'b1;
            @(posedge clk);
            #1;
            dif.pop = 1'b0;
            seen = 1'b1;
         end
      end
      ps2_clk = 1'b1;
      chk("push_seen", seen, 1);
      model_byte(b, 1'b1);
      repeat (30) @(negedge clk);
      settled = 1'b1;
   endtask

   task automatic do_pop(input bit d, input bit r);
      @(negedge clk);
      dif.pop = d;
      rif.pop = r;
      @(posedge clk);
      #1;
      dif.pop = 1'b0;
      rif.pop = 1'b0;
      if (d && qd.size() != 0) qd.delete(0);
      if (r && qr.size() != 0) qr.delete(0);
   endtask

   task automatic do_clr();
      @(negedge clk);
      dif.clr_status = 1'b1;
      rif.clr_status = 1'b1;
      @(posedge clk);
      #1;
      dif.clr_status = 1'b0;
      rif.clr_status = 1'b0;
      ovf_dm = 1'b0;
      ovf_rm = 1'b0;
      err_m  = 8'd0;
   endtask

   initial begin
      dif.pop = 1'b0; dif.clr_status = 1'b0;
      rif.pop = 1'b0; rif.clr_status = 1'b0;
      repeat (2) @(negedge clk);
      settled = 1'b1;
      chk("rst_valid", dif.ev_valid, 0);
      chk("rst_data",  dif.ev_data, 0);
      chk("rst_count", dif.ev_count, 0);
      rst = 1'b0;

      // single make code
      frame(8'h1C, 1'b0);
      chk("1c_data",  dif.ev_data, 16'h001C);
      chk("1c_count", dif.ev_count, 1);
      chk("1c_valid", dif.ev_valid, 1);
      do_pop(1'b1, 1'b1);
      @(negedge clk);
      chk("pop_valid", dif.ev_valid, 0);
      chk("pop_data",  dif.ev_data, 0);
      do_pop(1'b1, 1'b1);

      // extended break sequence, decoded vs raw
      frame(8'hE0, 1'b0);
      frame(8'hF0, 1'b0);
      frame(8'h75, 1'b0);
      chk("ext_brk_data",  dif.ev_data, 16'h0375);
      chk("ext_brk_count", dif.ev_count, 1);
      chk("raw_0", rif.ev_data, 16'h00E0);
      do_pop(1'b0, 1'b1);
      @(negedge clk);
      chk("raw_1", rif.ev_data, 16'h00F0);
      do_pop(1'b0, 1'b1);
      @(negedge clk);
      chk("raw_2", rif.ev_data, 16'h0075);
      do_pop(1'b1, 1'b1);

      // bad parity, then bad stop bit
      bad_frame(mk(8'h1C, 1'b1, 1'b1), 11, 30);
      chk("err_parity", dif.err_cnt, 1);
      bad_frame(mk(8'h1C, 1'b0, 1'b0), 11, 30);
      chk("err_stop", dif.err_cnt, 2);

      // stalled frame: start plus 3 data bits, then silence
      bad_frame(mk(8'h29, 1'b0, 1'b1), 4, TO + 40);
      chk("err_timeout", dif.err_cnt, 3);
      frame(8'h29, 1'b0);
      chk("after_to", dif.ev_data, 16'h0029);
      do_pop(1'b1, 1'b1);

      // overflow with depth 4
      for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0);
      chk("ovf_count", dif.ev_count, 4);
      chk("ovf_flag",  dif.overflow, 1);
      chk("ovf_head",  dif.ev_data, 16'h0001);
      do_clr();
      @(negedge clk);
      chk("clr_ovf", dif.overflow, 0);
      chk("clr_err", dif.err_cnt, 0);

      // push coinciding with pop while full
      frame_pop(8'h06);
      chk("fullpp_ovf",  dif.overflow, 0);
      chk("fullpp_head", dif.ev_data, 16'h0002);
      chk("fullpp_cnt",  dif.ev_count, 4);
      chk("raw_drop",    rif.overflow, 1);
      for (int i = 0; i < NQ; i++) do_pop(1'b1, 1'b1);
      do_clr();

      // push coinciding with pop while empty
      frame_pop(8'h07);
      chk("emptypp", dif.ev_data, 16'h0007);
      do_pop(1'b1, 1'b1);

      // short ps2_clk glitch mid-frame
      frame(8'h5A, 1'b1);
      chk("glitch", dif.ev_data, 16'h005A);

      // reset during a frame with an ext prefix pending
      frame(8'hE0, 1'b0);
      settled = 1'b0;
      send_bits(mk(8'h44, 1'b0, 1'b1), 5, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      qd.delete();
      qr.delete();
      ovf_dm = 1'b0; ovf_rm = 1'b0; err_m = 8'd0; ext_m = 1'b0; brk_m = 1'b0;
      settled = 1'b1;
      @(negedge clk);
      chk("midrst_valid", dif.ev_valid, 0);
      chk("midrst_raw",   rif.ev_count, 0);
      repeat (5) @(negedge clk);
      frame(8'h33, 1'b0);
      chk("post_rst", dif.ev_data, 16'h0033);

      settled = 1'b0;
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench still running at %0t", $time);
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 receiver, next generation of the keyboard input path. Adds a ps2_clk glitch filter, a frame timeout watchdog, optional E0/F0 prefix decoding into key events, and a configurable-depth FIFO. Overflow keeps queued data; the FIFO is never flushed. Sits between the PS/2 pins and the peripheral bus slave, which pops events through a valid/pop handshake.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 events (legal range 1..8).
FILTER_LEN, 4, consecutive equal synced ps2_clk samples needed to change the filtered clock (>=1).
TIMEOUT_CYC, 50000, clk cycles allowed between falling edges inside a frame before abort.
DECODE, 1, 1 = merge E0/F0 prefixes into one event; 0 = push every raw byte.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ps2_clk  in  1  PS/2 clock pin, asynchronous
ps2_data  in  1  PS/2 data pin, asynchronous
pop  in  1  consume head event; ignored when ev_valid=0
ev_valid  out  1  FIFO not empty
ev_data  out  16  head event: [7:0] code, [8] ext, [9] brk, [15:10] 0; forced 0 when empty
ev_count  out  DEPTH_LOG2+1  number of events held
overflow  out  1  sticky: an event was dropped because the FIFO was full
err_cnt  out  8  saturating count of bad or aborted frames
clr_status  in  1  clears overflow and err_cnt

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE; pointers, count, flags, overflow and err_cnt to 0; ev_valid=0, ev_data=0; sync and filter flops to 1 (bus idle high). FIFO storage is not reset.
- Input path: 2-flop synchronizer on each pin.
- Filter: filt_clk takes the synced ps2_clk value after it has been stable and different for FILTER_LEN consecutive cycles.
- fall: one-cycle pulse when filt_clk goes from 1 to 0. Synced ps2_data is sampled on the fall cycle.
- Frame FSM, advances only on fall:
  - IDLE: data=0 (start bit) -> DATA with bitcnt=0; data=1 -> stay, no error.
  - DATA: shift bits LSB first; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: frame is good if stop=1 and the 8 data bits plus parity have an odd number of ones. Good -> byte_valid pulse for 1 cycle. Bad -> err_cnt+1. Either way -> IDLE.
- Watchdog: counts clk cycles while not IDLE and resets on every fall. When it reaches TIMEOUT_CYC: FSM -> IDLE, partial byte discarded, err_cnt+1.
- err_cnt saturates at 255.
- Decoder, when DECODE=1, acts on byte_valid:
  - E0 sets ext_f, no push.
  - F0 sets brk_f, no push.
  - Any other byte pushes {brk_f, ext_f, byte} and clears both flags.
  - Repeated prefixes just re-set their flag.
  - Decoder flags are not cleared on frame error.
- Raw mode (DECODE=0): every good byte pushes {8'h0, byte}.
- Latency: push is registered in the cycle after byte_valid; ev_valid and ev_count update on the following clk edge.
- FIFO is show-ahead: ev_data = mem[rd_ptr] while count != 0.
  - pop && ev_valid: rd_ptr+1, count-1 on the next edge.
  - Pointers wrap modulo depth.
- FIFO boundaries:
  - Push while full with no pop: event dropped, overflow set, contents untouched.
  - Push and pop in the same cycle while full: both accepted, count unchanged, no overflow.
  - Push and pop while empty: no pop happens; the push is accepted.
  - Pop while empty: ignored.
- clr_status: clears overflow and err_cnt. If a new overflow or error occurs in the same cycle, the new event wins: overflow=1 or err_cnt=1.
- rst mid-frame: abandons the partial frame, decoder flags and FIFO contents, with no error counted.

Decomposition:
- Package ps2_pkg:
  - frame state enum {IDLE, DATA, PARITY, STOP};
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - event field indices EV_CODE_LSB=0, EV_EXT=8, EV_BRK=9, and EV_W=16.
- Sub-module: sync_fifo (parameters WIDTH and DEPTH_LOG2). It provides show-ahead read, count output, and a full/drop indication. It is reusable by other peripherals.
- Receiver FSM, filter, watchdog and decoder stay in ps2_rx_fifo.

Test Plan:
- Single frame for byte 8'h1C (parity=0, stop=1), DECODE=1 -> ev_valid=1, ev_data=16'h001C, ev_count=1; pop -> ev_valid=0, ev_data=0.
- Frames E0, F0, 75 -> exactly one event 16'h0375 (brk=1, ext=1); DECODE=0 with the same frames -> three events 00E0, 00F0, 0075 in order.
- 8'h1C with the parity bit flipped -> no event, err_cnt=1. Stop bit held at 0 -> err_cnt=2.
- Start bit plus 3 data bits, then idle for TIMEOUT_CYC+10 cycles -> FSM back in IDLE, err_cnt+1. A following good frame 8'h29 -> event 16'h0029.
- DEPTH_LOG2=2:
  - 5 frames 01..05 with no pop -> ev_count=4, overflow=1, head=0001; pops return 01, 02, 03, 04.
  - Push coinciding with pop while full -> no overflow.
  - clr_status -> overflow=0, err_cnt=0.
- Glitch of FILTER_LEN-1 cycles on ps2_clk mid-frame -> no extra bit sampled, byte correct. rst asserted mid-frame -> all outputs 0; the next full frame is received cleanly.
